posit_decode_sequencer: RTL and testbench
=========================================

// Module: posit_decode_sequencer
// PURPOSE
//  Time-multiplexes ONE posit_decoder instance to decode an operand pair (a, b) into two FIR words.
//  Sits between the PPU operand front end and the FIR arithmetic core.
//  Uses valid/ready handshakes on both sides; sustained throughput is one pair per 3 cycles.
//  Also flags zero and NaR operands, which the decoder does not handle.
// PARAMETERS
//  N   -1  posit width; ppu_pkg sizes posit_t, fir_t, TE_BITS and MANT_SIZE from it
//  ES  -1  posit exponent-field width; passed unchanged to posit_decoder
// PORTS
//  clk_i        in   1            clock; single clock domain
//  rst_i        in   1            reset; synchronous, active-high
//  in_valid_i   in   1            operand pair valid
//  in_ready_o   out  1            sequencer can accept a pair this cycle
//  operand_a_i  in   N (posit_t)  operand a bits
//  operand_b_i  in   N (posit_t)  operand b bits
//  out_valid_o  out  1            decoded pair valid
//  out_ready_i  in   1            consumer accepts the decoded pair
//  fir_a_o      out  fir_t        FIR of operand a; '0 if a is special
//  fir_b_o      out  fir_t        FIR of operand b; '0 if b is special
//  is_zero_o    out  2            [0]=a==0, [1]=b==0
//  is_nar_o     out  2            [0]=a==NaR, [1]=b==NaR (NaR = 1'b1 followed by N-1 zeros)
// BEHAVIOUR
//  Reset (sampled on posedge clk_i while rst_i=1):
//   - state=IDLE; out_valid_o=0; fir_a_o=fir_b_o='0; is_zero_o=is_nar_o=2'b00.
//   - A transaction in flight is dropped and produces no output.
//   - in_ready_o=0 while rst_i=1.
//  FSM states: IDLE, DEC_A, DEC_B, DONE.
//   - IDLE: in_ready_o=1. On accept (in_valid_i & in_ready_o): register a and b, compute the special flags from the raw bits -> DEC_A.
//   - DEC_A: decoder input = a_reg; register the decoder output into fir_a (or '0 if a is special) -> DEC_B.
//   - DEC_B: decoder input = b_reg; register into fir_b likewise -> DONE.
//   - DONE: out_valid_o=1; in_ready_o=out_ready_i.
//     - out_ready_i=1 with in_valid_i=1 (simultaneous retire/accept): capture the new pair -> DEC_A.
//     - out_ready_i=1 with in_valid_i=0 -> IDLE.
//     - out_ready_i=0: hold.
//  Handshake and timing:
//   - Latency: a pair accepted at edge t gives out_valid_o=1 in the cycle after edge t+2.
//   - Outputs are registered and stable while out_valid_o & !out_ready_i.
//   - The accepted-pair registers are not overwritten until DONE retires; there is no bypass and no input buffering beyond one pair.
//   - in_valid_i may drop without being accepted (no input-side obligation). out_valid_o must not drop until accepted.
//  Decoder path:
//   - Decoder input mux: DEC_A selects a_reg, any other state selects b_reg. The mux is combinational; the decoder output is registered.
//   - Non-special FIR fields are bit-identical to the standalone posit_decoder output for the same bits.
// STRUCTURE
//  - ppu_pkg adds: typedef enum logic [1:0] {IDLE, DEC_A, DEC_B, DONE} dec_seq_state_t; function is_nar(posit_t).
//  - posit_t and fir_t are reused from ppu_pkg.
//  - One sub-module instance: posit_decoder (N, ES). Everything else is local FSM, mux and registers.
// TESTING  (N=16, ES=1; golden FIR from a standalone posit_decoder model)
//  - a=0x4000 (1.0), b=0x5000 (2.0) -> fir_a{sign=0, te=0}, fir_b{sign=0, te=1}, flags 00, out_valid_o 3 cycles after accept.
//  - a=0xC000, b=0x0001 (minpos) -> fir_a{sign=1, te=0}, fir_b{te=-28}; no flags set.
//  - a=0x0000, b=0x8000 -> is_zero_o=2'b01, is_nar_o=2'b10, both FIR outputs '0.
//  - out_ready_i=0 for 5 cycles in DONE -> outputs stable, in_ready_o=0; then ready with next pair valid -> accepted in the same cycle, next result 3 cycles later.
//  - Back-to-back stream of 8 pairs with out_ready_i=1 -> 8 correct results, one every 3 cycles, none lost or duplicated.
//  - rst_i asserted in DEC_B -> out_valid_o=0 next cycle, state IDLE, the dropped pair is never output.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared PPU types: posit and FIR (sign, total exponent, mantissa) formats plus
// the decode-sequencer state encoding.
package ppu_pkg;

    localparam int N  = 16;
    localparam int ES = 1;

    // Largest |total exponent| is (N-2) << ES; one extra bit for sign.
    localparam int TE_BITS   = $clog2((N - 1) << ES) + 1;
    // Hidden bit plus the widest possible fraction field.
    localparam int MANT_SIZE = N - ES - 2;

    typedef logic [N-1:0] posit_t;

    typedef struct packed {
        logic                      sign;
        logic signed [TE_BITS-1:0] total_exponent;
        logic [MANT_SIZE-1:0]      mant;
    } fir_t;

    typedef enum logic [1:0] {IDLE, DEC_A, DEC_B, DONE} dec_seq_state_t;

    function automatic logic is_nar(input posit_t p);
        posit_t nar;
        nar = {1'b1, {(N - 1){1'b0}}};
        return p == nar;
    endfunction

endpackage

// File: rtl/posit_decoder.sv
// Combinational posit-to-FIR decoder. Zero and NaR are not recognised here;
// callers must mask them.
module posit_decoder
    import ppu_pkg::*;
#(
    parameter int N  = ppu_pkg::N,
    parameter int ES = ppu_pkg::ES
) (
    input  posit_t i_posit,
    output fir_t   o_fir
);

    logic [N-1:0]              w_abs;
    logic [N-2:0]              w_rem;
    logic [N-2:0]              w_shifted;
    logic [$clog2(N):0]        w_run;
    logic                      w_run_done;
    logic signed [TE_BITS-1:0] w_run_s;
    logic signed [TE_BITS-1:0] w_k;
    logic [ES-1:0]             w_exp;
    logic                      w_unused;

    // Negative posits are decoded from their two's complement.
    assign w_abs = i_posit[N-1] ? (~i_posit + 1'b1) : i_posit;
    assign w_rem = w_abs[N-2:0];

    always_comb begin
        w_run      = '0;
        w_run_done = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!w_run_done && (w_rem[i] == w_rem[N-2])) begin
                w_run = w_run + 1'b1;
            end else begin
                w_run_done = 1'b1;
            end
        end
    end

    // Drop the regime run and its terminator; exponent then fraction remain MSB-aligned.
    assign w_shifted = w_rem << (w_run + 1'b1);
    assign w_exp     = w_shifted[N-2 -: ES];
    assign w_run_s   = TE_BITS'(w_run);
    assign w_k       = w_rem[N-2] ? (w_run_s - TE_BITS'(1)) : -w_run_s;

    always_comb begin
        o_fir                = '0;
        o_fir.sign           = i_posit[N-1];
        o_fir.total_exponent = (w_k <<< ES) | TE_BITS'(w_exp);
        o_fir.mant           = {1'b1, w_shifted[N-2-ES -: MANT_SIZE-1]};
    end

    assign w_unused = ^w_shifted[N-2-ES-(MANT_SIZE-1):0];

endmodule

// File: rtl/posit_decode_sequencer.sv
// Decodes an operand pair through a single shared posit_decoder over three
// cycles, with valid/ready on both sides and zero/NaR flagging.
module posit_decode_sequencer
    import ppu_pkg::*;
#(
    parameter int N  = ppu_pkg::N,
    parameter int ES = ppu_pkg::ES
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  posit_t     operand_a_i,
    input  posit_t     operand_b_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output fir_t       fir_a_o,
    output fir_t       fir_b_o,
    output logic [1:0] is_zero_o,
    output logic [1:0] is_nar_o
);

    dec_seq_state_t r_state;
    dec_seq_state_t w_next;
    posit_t         r_a;
    posit_t         r_b;
    fir_t           r_fir_a;
    fir_t           r_fir_b;
    logic [1:0]     r_zero;
    logic [1:0]     r_nar;
    logic           w_in_ready;
    logic           w_out_valid;
    logic           w_accept;
    posit_t         w_dec_in;
    fir_t           w_dec_fir;

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid_i) w_next = DEC_A;
            end
            DEC_A: w_next = DEC_B;
            DEC_B: w_next = DONE;
            DONE: begin
                w_out_valid = 1'b1;
                w_in_ready  = out_ready_i;
                if (out_ready_i) w_next = in_valid_i ? DEC_A : IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (rst_i) w_in_ready = 1'b0;
    end

    assign w_accept = in_valid_i & w_in_ready;
    assign w_dec_in = (r_state == DEC_A) ? r_a : r_b;

    posit_decoder #(
        .N  (N),
        .ES (ES)
    ) u_posit_decoder (
        .i_posit (w_dec_in),
        .o_fir   (w_dec_fir)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_fir_a <= '0;
            r_fir_b <= '0;
            r_zero  <= '0;
            r_nar   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a    <= operand_a_i;
                r_b    <= operand_b_i;
                r_zero <= {operand_b_i == '0, operand_a_i == '0};
                r_nar  <= {is_nar(operand_b_i), is_nar(operand_a_i)};
            end
            if (r_state == DEC_A) begin
                r_fir_a <= (r_zero[0] | r_nar[0]) ? '0 : w_dec_fir;
            end
            if (r_state == DEC_B) begin
                r_fir_b <= (r_zero[1] | r_nar[1]) ? '0 : w_dec_fir;
            end
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = w_out_valid;
    assign fir_a_o     = r_fir_a;
    assign fir_b_o     = r_fir_b;
    assign is_zero_o   = r_zero;
    assign is_nar_o    = r_nar;

endmodule

// File: tb/tb_posit_decode_sequencer.sv
// Directed bench for posit_decode_sequencer (N=16, ES=1) with hand-computed FIR values.
module tb_posit_decode_sequencer;
    import ppu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       in_valid_i;
    logic       in_ready_o;
    posit_t     operand_a_i;
    posit_t     operand_b_i;
    logic       out_valid_o;
    logic       out_ready_i;
    fir_t       fir_a_o;
    fir_t       fir_b_o;
    logic [1:0] is_zero_o;
    logic [1:0] is_nar_o;

    int n_checks = 0;
    int n_fail   = 0;

    posit_decode_sequencer #(
        .N  (16),
        .ES (1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .fir_a_o     (fir_a_o),
        .fir_b_o     (fir_b_o),
        .is_zero_o   (is_zero_o),
        .is_nar_o    (is_nar_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic fir_t mk_fir(input logic s, input int te, input logic [MANT_SIZE-1:0] m);
        fir_t f;
        f.sign           = s;
        f.total_exponent = TE_BITS'(te);
        f.mant           = m;
        return f;
    endfunction

    // Counts negedges from the accept edge until out_valid_o rises (bounded).
    task automatic wait_valid(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!out_valid_o && cnt < 12);
    endtask

    task automatic run_pair(input string tag, input posit_t a, input posit_t b,
                            input fir_t efa, input fir_t efb,
                            input logic [1:0] ez, input logic [1:0] en);
        int lat;
        @(negedge clk);
        in_valid_i  = 1'b1;
        operand_a_i = a;
        operand_b_i = b;
        #1 check_eq({tag, "_in_ready"}, 32'(in_ready_o), 32'd1);
        @(posedge clk);
        #1 in_valid_i = 1'b0;
        wait_valid(lat);
        check_eq({tag, "_latency"}, 32'(lat), 32'd3);
        check_eq({tag, "_fir_a"}, 32'(fir_a_o), 32'(efa));
        check_eq({tag, "_fir_b"}, 32'(fir_b_o), 32'(efb));
        check_eq({tag, "_zero"}, 32'(is_zero_o), 32'(ez));
        check_eq({tag, "_nar"}, 32'(is_nar_o), 32'(en));
        out_ready_i = 1'b1;
        @(posedge clk);
        #1 out_ready_i = 1'b0;
        @(negedge clk);
        check_eq({tag, "_retired"}, 32'(out_valid_o), 32'd0);
    endtask

    posit_t tbl_p [8];
    fir_t   tbl_f [8];

    initial begin
        int   lat;
        int   tx;
        int   rx;
        int   last_cyc;
        int   seen;
        fir_t hold_a;
        fir_t hold_b;

        tbl_p[0] = 16'h4000; tbl_f[0] = mk_fir(1'b0,  0, 13'h1000);
        tbl_p[1] = 16'h5000; tbl_f[1] = mk_fir(1'b0,  1, 13'h1000);
        tbl_p[2] = 16'h6000; tbl_f[2] = mk_fir(1'b0,  2, 13'h1000);
        tbl_p[3] = 16'h7000; tbl_f[3] = mk_fir(1'b0,  4, 13'h1000);
        tbl_p[4] = 16'h3000; tbl_f[4] = mk_fir(1'b0, -1, 13'h1000);
        tbl_p[5] = 16'h4800; tbl_f[5] = mk_fir(1'b0,  0, 13'h1800);
        tbl_p[6] = 16'h2000; tbl_f[6] = mk_fir(1'b0, -2, 13'h1000);
        tbl_p[7] = 16'hB000; tbl_f[7] = mk_fir(1'b1,  1, 13'h1000);

        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        operand_a_i = '0;
        operand_b_i = '0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready_o), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid_o), 32'd0);
        check_eq("rst_fir_a", 32'(fir_a_o), 32'd0);
        check_eq("rst_fir_b", 32'(fir_b_o), 32'd0);
        check_eq("rst_flags", 32'({is_zero_o, is_nar_o}), 32'd0);
        rst_i = 1'b0;
        #1 check_eq("idle_in_ready", 32'(in_ready_o), 32'd1);

        run_pair("one_two", 16'h4000, 16'h5000, mk_fir(1'b0, 0, 13'h1000),
                 mk_fir(1'b0, 1, 13'h1000), 2'b00, 2'b00);
        run_pair("neg_minpos", 16'hC000, 16'h0001, mk_fir(1'b1, 0, 13'h1000),
                 mk_fir(1'b0, -28, 13'h1000), 2'b00, 2'b00);
        run_pair("maxpos", 16'h7FFF, 16'h4800, mk_fir(1'b0, 28, 13'h1000),
                 mk_fir(1'b0, 0, 13'h1800), 2'b00, 2'b00);
        run_pair("special", 16'h0000, 16'h8000, '0, '0, 2'b01, 2'b10);

        // Backpressure in DONE, then retire and accept in the same cycle.
        @(negedge clk);
        in_valid_i  = 1'b1;
        operand_a_i = 16'h4800;
        operand_b_i = 16'h3000;
        @(posedge clk);
        #1 in_valid_i = 1'b0;
        wait_valid(lat);
        check_eq("stall_latency", 32'(lat), 32'd3);
        hold_a = tbl_f[5];
        hold_b = tbl_f[4];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall_valid", 32'(out_valid_o), 32'd1);
            check_eq("stall_in_ready", 32'(in_ready_o), 32'd0);
            check_eq("stall_fir_a", 32'(fir_a_o), 32'(hold_a));
            check_eq("stall_fir_b", 32'(fir_b_o), 32'(hold_b));
        end
        @(negedge clk);
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        operand_a_i = 16'h7000;
        operand_b_i = 16'hB000;
        #1 check_eq("overlap_in_ready", 32'(in_ready_o), 32'd1);
        @(posedge clk);
        #1;
        out_ready_i = 1'b0;
        in_valid_i  = 1'b0;
        wait_valid(lat);
        check_eq("overlap_latency", 32'(lat), 32'd3);
        check_eq("overlap_fir_a", 32'(fir_a_o), 32'(tbl_f[3]));
        check_eq("overlap_fir_b", 32'(fir_b_o), 32'(tbl_f[7]));
        out_ready_i = 1'b1;
        @(posedge clk);
        #1 out_ready_i = 1'b0;

        // Back-to-back stream of 8 pairs with the consumer always ready.
        out_ready_i = 1'b1;
        tx          = 0;
        rx          = 0;
        last_cyc    = 0;
        for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
            @(negedge clk);
            if (out_valid_o && rx < 8) begin
                check_eq("stream_fir_a", 32'(fir_a_o), 32'(tbl_f[rx]));
                check_eq("stream_fir_b", 32'(fir_b_o), 32'(tbl_f[(rx + 3) % 8]));
                if (rx > 0) check_eq("stream_spacing", 32'(cyc - last_cyc), 32'd3);
                last_cyc = cyc;
                rx++;
            end
            in_valid_i = (tx < 8);
            if (tx < 8) begin
                operand_a_i = tbl_p[tx];
                operand_b_i = tbl_p[(tx + 3) % 8];
            end
            #1;
            if (in_valid_i && in_ready_o) tx++;
        end
        in_valid_i = 1'b0;
        check_eq("stream_count", 32'(rx), 32'd8);
        @(negedge clk);
        check_eq("stream_no_dup", 32'(out_valid_o), 32'd0);
        out_ready_i = 1'b0;

        // Reset while in DEC_B drops the pair.
        @(negedge clk);
        in_valid_i  = 1'b1;
        operand_a_i = 16'h6000;
        operand_b_i = 16'h2000;
        @(posedge clk);
        #1 in_valid_i = 1'b0;
        @(posedge clk);
        #1 rst_i = 1'b1;
        @(negedge clk);
        check_eq("rstdecb_in_ready", 32'(in_ready_o), 32'd0);
        @(negedge clk);
        check_eq("rstdecb_out_valid", 32'(out_valid_o), 32'd0);
        check_eq("rstdecb_fir_a", 32'(fir_a_o), 32'd0);
        rst_i       = 1'b0;
        out_ready_i = 1'b1;
        seen        = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid_o) seen++;
        end
        check_eq("rstdecb_dropped", 32'(seen), 32'd0);
        #1 check_eq("rstdecb_idle_ready", 32'(in_ready_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
